add_sub_pipe: RTL and testbench



---
 rtl/add_sub_pkg.sv | 26 ++
 rtl/add_sub_slice.sv | 35 +++
 rtl/add_sub_pipe.sv | 154 +++++++++++++++
 tb/tb_add_sub_pipe.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared definitions for the pipelined adder-subtractor.
//   OP_ADD / OP_SUB : encodings of the select input
//   ctl_t           : per-beat side-band bits carried down the pipe with
//                     the beat (operand MSBs for overflow, saturation enable)
//   sat_max/sat_min : most positive / most negative two's-complement
//                     pattern of a given width (width <= 64)
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic xm;   // x MSB
    logic bm;   // MSB of the effective second operand (y, or ~y on subtract)
    logic sat;  // clamp on signed overflow
  } ctl_t;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice: one CHUNK-bit registered carry-chain slice.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance enable; the slice holds its result while low
//   a, b     : operand slices (b already inverted for subtract)
//   cin      : carry in from the previous slice (or the subtract +1)
//   sum      : registered slice sum
//   cout     : registered carry out of the slice
module add_sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= full[CHUNK-1:0];
      cout <= full[CHUNK];
    end
  end

endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined signed/unsigned adder-subtractor, valid/ready
// handshake, optional signed saturation. The carry chain is cut into
// STAGES = WIDTH/CHUNK slices, one register stage per slice.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = pipe advance enable)
//   x, y                 : operands
//   select               : OP_ADD (x+y) or OP_SUB (x-y)
//   sat_en               : clamp ans on signed overflow
//   out_valid / out_ready: result handshake
//   ans                  : result (saturated when sat_en && ovf)
//   cout                 : raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  : signed overflow, independent of sat_en
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             select,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic                en;
  logic [STAGES:1]     vld_pipe;   // vld_pipe[k+1] = stage k holds a beat
  ctl_t [STAGES-1:0]   ctl;
  logic [WIDTH-1:0]    yb;         // effective second operand
  logic [WIDTH-1:0]    raw;
  ctl_t                ctl_o;

  // Slice interconnect, driven per stage from the generate loop.
  wire  [STAGES-1:0][CHUNK-1:0] sa, sb, ss;
  wire  [STAGES-1:0]            sc, sco;

  // Whole pipe advances together; a full output that is not taken
  // freezes every stage, bubbles included.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign yb        = (select == OP_ADD) ? y : ~y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ctl      <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      ctl[0]      <= '{xm: x[WIDTH-1], bm: yb[WIDTH-1], sat: sat_en};
      for (int k = 1; k < STAGES; k++) begin
        vld_pipe[k+1] <= vld_pipe[k];
        ctl[k]        <= ctl[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg

    // Slice inputs: stage 0 takes the live operands and the subtract +1,
    // later stages take their slice from the skew registers of the
    // previous stage and the previous slice's carry.
    if (k == 0) begin : g_src
      assign sa[0] = x[CHUNK-1:0];
      assign sb[0] = yb[CHUNK-1:0];
      assign sc[0] = (select == OP_SUB);
    end else begin : g_src
      assign sa[k] = g_stg[k-1].g_skew.xr[CHUNK-1:0];
      assign sb[k] = g_stg[k-1].g_skew.br[CHUNK-1:0];
      assign sc[k] = sco[k-1];
    end

    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (sa[k]),
      .b    (sb[k]),
      .cin  (sc[k]),
      .sum  (ss[k]),
      .cout (sco[k])
    );

    // Operand slices not yet consumed ride along with the beat; each
    // stage keeps only the slices above the one it just added.
    if (k < STAGES - 1) begin : g_skew
      localparam int RW = WIDTH - (k + 1) * CHUNK;
      logic [RW-1:0] xr, br, xn, bn;

      if (k == 0) begin : g_nxt
        assign xn = x[WIDTH-1:CHUNK];
        assign bn = yb[WIDTH-1:CHUNK];
      end else begin : g_nxt
        assign xn = g_stg[k-1].g_skew.xr[RW+CHUNK-1:CHUNK];
        assign bn = g_stg[k-1].g_skew.br[RW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xr <= '0;
          br <= '0;
        end else if (en) begin
          xr <= xn;
          br <= bn;
        end
      end
    end

    // Finished lower result slices are delayed so that at stage k the
    // slices 0..k-1 line up with the slice-k sum register.
    if (k > 0) begin : g_lo
      logic [k*CHUNK-1:0] lo, lon;

      if (k == 1) begin : g_nxt
        assign lon = ss[0];
      end else begin : g_nxt
        assign lon = {ss[k-1], g_stg[k-1].g_lo.lo};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     lo <= '0;
        else if (en) lo <= lon;
      end
    end

  end

  if (STAGES == 1) begin : g_raw
    assign raw = ss[0];
  end else begin : g_raw
    assign raw = {ss[STAGES-1], g_stg[STAGES-1].g_lo.lo};
  end

  // Overflow and clamping are pure functions of final-stage registers, so
  // ans/cout/ovf stay put while the output is stalled. All-zero reset
  // state gives ovf = 0 and ans = 0.
  assign ctl_o = ctl[STAGES-1];
  assign ovf   = (ctl_o.xm == ctl_o.bm) && (raw[WIDTH-1] != ctl_o.xm);
  assign ans   = (ctl_o.sat && ovf) ? (ctl_o.xm ? SMIN : SMAX) : raw;
  assign cout  = sco[STAGES-1];

endmodule

// File: tb/tb_add_sub_pipe.sv
module tb_add_sub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a_: WIDTH=8/CHUNK=4, b_: WIDTH=16/CHUNK=4, c_: WIDTH=8/CHUNK=8
  logic        a_iv = 0, a_ir, a_sel = 0, a_sat = 0, a_ov, a_ordy = 1, a_cout, a_ovf;
  logic [7:0]  a_x = 0, a_y = 0, a_ans;
  logic        b_iv = 0, b_ir, b_sel = 0, b_sat = 0, b_ov, b_ordy = 1, b_cout, b_ovf;
  logic [15:0] b_x = 0, b_y = 0, b_ans;
  logic        c_iv = 0, c_ir, c_sel = 0, c_sat = 0, c_ov, c_ordy = 1, c_cout, c_ovf;
  logic [7:0]  c_x = 0, c_y = 0, c_ans;

  logic [17:0] q_a[$], q_b[$], q_c[$];

  add_sub_pipe #(.WIDTH(8), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .y(a_y),
    .select(a_sel), .sat_en(a_sat), .out_valid(a_ov), .out_ready(a_ordy),
    .ans(a_ans), .cout(a_cout), .ovf(a_ovf));

  add_sub_pipe #(.WIDTH(16), .CHUNK(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .y(b_y),
    .select(b_sel), .sat_en(b_sat), .out_valid(b_ov), .out_ready(b_ordy),
    .ans(b_ans), .cout(b_cout), .ovf(b_ovf));

  add_sub_pipe #(.WIDTH(8), .CHUNK(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .x(c_x), .y(c_y),
    .select(c_sel), .sat_en(c_sat), .out_valid(c_ov), .out_ready(c_ordy),
    .ans(c_ans), .cout(c_cout), .ovf(c_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic. Returns {ovf, cout, ans[15:0]}.
  function automatic logic [17:0] model(input int w, input int ux, input int uy,
                                        input bit sel, input bit sat);
    int umax, smax, smin, sx, sy, res, a;
    bit o, c;
    umax = 1 << w;
    smax = (1 << (w - 1)) - 1;
    smin = -(1 << (w - 1));
    sx   = (ux > smax) ? ux - umax : ux;
    sy   = (uy > smax) ? uy - umax : uy;
    res  = sel ? sx - sy : sx + sy;
    o    = (res > smax) || (res < smin);
    c    = sel ? (ux >= uy) : (ux + uy >= umax);
    a    = (sat && o) ? ((res > smax) ? smax : smin) : res;
    a    = a & (umax - 1);
    return {o, c, a[15:0]};
  endfunction

  // Scoreboards: inputs and out_ready are changed just after posedge, so at
  // negedge they show what the next edge will see.
  logic [17:0] ea, eb, ec;
  always @(negedge clk) if (!rst) begin
    if (a_ov && a_ordy) begin
      if (q_a.size() == 0) chk("a_extra", 32'(a_ov), 32'd0);
      else begin ea = q_a.pop_front(); chk("a_res", 32'({a_ovf, a_cout, 8'h00, a_ans}), 32'(ea)); end
    end
    if (a_iv && a_ir) q_a.push_back(model(8, int'(a_x), int'(a_y), a_sel, a_sat));
    if (b_ov && b_ordy) begin
      if (q_b.size() == 0) chk("b_extra", 32'(b_ov), 32'd0);
      else begin eb = q_b.pop_front(); chk("b_res", 32'({b_ovf, b_cout, b_ans}), 32'(eb)); end
    end
    if (b_iv && b_ir) q_b.push_back(model(16, int'(b_x), int'(b_y), b_sel, b_sat));
    if (c_ov && c_ordy) begin
      if (q_c.size() == 0) chk("c_extra", 32'(c_ov), 32'd0);
      else begin ec = q_c.pop_front(); chk("c_res", 32'({c_ovf, c_cout, 8'h00, c_ans}), 32'(ec)); end
    end
    if (c_iv && c_ir) q_c.push_back(model(8, int'(c_x), int'(c_y), c_sel, c_sat));
  end

  task automatic drv(input logic [7:0] xv, input logic [7:0] yv, input logic sv, input logic tv);
    a_iv = 1; a_x = xv; a_y = yv; a_sel = sv; a_sat = tv;
  endtask

  // Single beat on dut_a with out_ready high: result must show 2 edges
  // after the accept edge, with the given {ovf, cout, ans}.
  task automatic send_chk(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                          input logic sv, input logic tv, input logic [9:0] exp);
    @(posedge clk); #2; drv(xv, yv, sv, tv);
    @(posedge clk); #2; a_iv = 0;
    @(negedge clk); chk({tag, "_e1"}, 32'(a_ov), 32'd0);
    @(negedge clk); chk({tag, "_vld"}, 32'(a_ov), 32'd1);
    chk(tag, 32'({a_ovf, a_cout, a_ans}), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_ov",   32'(a_ov),   32'd0);
    chk("rst_ans",  32'(a_ans),  32'd0);
    chk("rst_cout", 32'(a_cout), 32'd0);
    chk("rst_ovf",  32'(a_ovf),  32'd0);
    chk("rst_b_ov", 32'(b_ov),   32'd0);
    repeat (2) @(posedge clk);
    #2; rst = 0;
    #1; chk("rst_ir", 32'(a_ir), 32'd1);

    send_chk("sub_0e_07", 8'h0E, 8'h07, 1'b1, 1'b0, 10'h107);
    send_chk("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0, 10'h0FF);
    send_chk("sub_a8_09", 8'hA8, 8'h09, 1'b1, 1'b0, 10'h19F);
    send_chk("add_ovf",   8'h76, 8'h56, 1'b0, 1'b0, 10'h2CC);
    send_chk("add_sat",   8'h76, 8'h56, 1'b0, 1'b1, 10'h27F);
    send_chk("sub_sat",   8'h80, 8'h01, 1'b1, 1'b1, 10'h380);

    // Back-to-back beats with a 3-cycle consumer stall after the first result.
    @(posedge clk); #2; drv(8'h00, 8'h01, 1'b1, 1'b0);
    @(posedge clk); #2; drv(8'hA8, 8'h09, 1'b1, 1'b0);
    @(posedge clk); #2; drv(8'h76, 8'h56, 1'b0, 1'b0); a_ordy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ir",  32'(a_ir), 32'd0);
      chk("stall_ov",  32'(a_ov), 32'd1);
      chk("stall_val", 32'({a_ovf, a_cout, a_ans}), 32'h0FF);
      @(posedge clk); #2;
    end
    a_ordy = 1;
    @(posedge clk); #2; drv(8'h76, 8'h56, 1'b0, 1'b1);
    @(posedge clk); #2; a_iv = 0;
    repeat (5) @(posedge clk);
    #2; chk("stall_drain", 32'(q_a.size()), 32'd0);

    // Reset with two beats in flight.
    drv(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #2; drv(8'h33, 8'h44, 1'b1, 1'b0);
    @(posedge clk); #2; a_iv = 0; rst = 1;
    #1;
    chk("mrst_ov",  32'(a_ov),  32'd0);
    chk("mrst_ans", 32'(a_ans), 32'd0);
    q_a.delete();
    repeat (2) @(posedge clk);
    #2; rst = 0;
    #1; chk("mrst_ir", 32'(a_ir), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("mrst_stale", 32'(a_ov), 32'd0);
    end

    // Random regression on all three configurations.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      a_iv = ($urandom_range(0, 3) != 0); a_x = 8'($urandom); a_y = 8'($urandom);
      a_sel = 1'($urandom); a_sat = 1'($urandom); a_ordy = ($urandom_range(0, 3) != 0);
      b_iv = ($urandom_range(0, 3) != 0); b_x = 16'($urandom); b_y = 16'($urandom);
      b_sel = 1'($urandom); b_sat = 1'($urandom); b_ordy = ($urandom_range(0, 3) != 0);
      c_iv = ($urandom_range(0, 3) != 0); c_x = 8'($urandom); c_y = 8'($urandom);
      c_sel = 1'($urandom); c_sat = 1'($urandom); c_ordy = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    a_iv = 0; b_iv = 0; c_iv = 0; a_ordy = 1; b_ordy = 1; c_ordy = 1;
    repeat (12) @(posedge clk);
    #2;
    chk("rnd_a_drain", 32'(q_a.size()), 32'd0);
    chk("rnd_b_drain", 32'(q_b.size()), 32'd0);
    chk("rnd_c_drain", 32'(q_c.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
